// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and bit helpers.
// Used by both the receive front end and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned DEFAULT_CLK_DIV = 651;

    localparam logic [3:0] VOTE_TICK_A = 4'd7;
    localparam logic [3:0] VOTE_TICK_B = 4'd8;
    localparam logic [3:0] VOTE_TICK_C = 4'd9;
    localparam logic [3:0] TCNT_LAST   = 4'(UART_OVERSAMPLE - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // True when data plus parity bit carry an even number of ones.
    function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
        return ~(^{d, p});
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and flags the wrap cycle.
// A synchronous restart re-phases the count to an external event.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    // Divisor counter with restart taking priority over the natural wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (restart) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: synchroniser, 16x oversampled majority vote, framing FSM.
// Optional even-parity framing when UART_RX_PARITY_EN is defined (default 8N1).
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       RX,
    output logic       rx_status,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       rx_busy
);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic       sync1_r, sync2_r, hist_r;
    rx_state_t  state_r, state_s;
    logic [3:0] tcnt_r;
    logic [2:0] bit_idx_r;
    logic [7:0] shift_r;
    logic       vote_a_r, vote_b_r;
    logic       tick_s, fall_s, restart_s, decide_s, wrap_s, vote_s;
    logic       status_s, ferr_s, frame_ok_s;

    uart_baud_tick #(.DIV(CLK_DIV)) u_tick (
        .clk     (sysclk),
        .reset   (reset),
        .restart (restart_s),
        .tick    (tick_s)
    );

    assign fall_s    = hist_r & ~sync2_r;
    assign restart_s = (state_r == IDLE) & fall_s;
    assign decide_s  = tick_s & (tcnt_r == VOTE_TICK_C);
    assign wrap_s    = tick_s & (tcnt_r == TCNT_LAST);
    assign vote_s    = majority3(vote_a_r, vote_b_r, sync2_r);

`ifdef UART_RX_PARITY_EN
    logic par_r;
    assign frame_ok_s = even_parity_ok(shift_r, par_r);

    // Parity bit captured from its own majority vote.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            par_r <= 1'b0;
        end else if ((state_r == PARITY) && decide_s) begin
            par_r <= vote_s;
        end else begin
            par_r <= par_r;
        end
    end
`else
    assign frame_ok_s = 1'b1;
`endif

    // Pin synchroniser and edge history; idle-high reset avoids a phantom start edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            hist_r  <= 1'b1;
        end else begin
            sync1_r <= RX;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Next-state and strobe decode; decisions are taken only at the tick-9 vote.
    always_comb begin
        state_s  = state_r;
        status_s = 1'b0;
        ferr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) state_s = START;
                else        state_s = IDLE;
            end
            START: begin
                if (decide_s && vote_s) state_s = IDLE;
                else if (wrap_s)        state_s = DATA;
                else                    state_s = START;
            end
            DATA: begin
                if (wrap_s && (bit_idx_r == 3'd7)) state_s = AFTER_DATA;
                else                               state_s = DATA;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (wrap_s) state_s = STOP;
                else        state_s = PARITY;
            end
`endif
            STOP: begin
                if (decide_s) begin
                    if (vote_s && frame_ok_s) status_s = 1'b1;
                    else                      ferr_s   = 1'b1;
                    if (vote_s) state_s = IDLE;
                    else        state_s = BREAK;
                end else begin
                    state_s = STOP;
                end
            end
            BREAK: begin
                if (sync2_r) state_s = IDLE;
                else         state_s = BREAK;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus sample counter aligned to the detected start edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r <= IDLE;
            tcnt_r  <= 4'd0;
        end else begin
            state_r <= state_s;
            if (restart_s)   tcnt_r <= 4'd0;
            else if (tick_s) tcnt_r <= tcnt_r + 4'd1;
            else             tcnt_r <= tcnt_r;
        end
    end

    // Vote samples, bit index and shift register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            vote_a_r  <= 1'b0;
            vote_b_r  <= 1'b0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            if (tick_s && (tcnt_r == VOTE_TICK_A)) vote_a_r <= sync2_r;
            if (tick_s && (tcnt_r == VOTE_TICK_B)) vote_b_r <= sync2_r;
            if (state_r == START) begin
                bit_idx_r <= 3'd0;
            end else if ((state_r == DATA) && wrap_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if ((state_r == DATA) && decide_s) shift_r[bit_idx_r] <= vote_s;
        end
    end

    // Registered outputs; rx_data only moves together with the good-frame strobe.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_status <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
            rx_data   <= 8'h00;
        end else begin
            rx_status <= status_s;
            frame_err <= ferr_s;
            rx_busy   <= (state_s != IDLE);
            if (status_s) rx_data <= shift_r;
            else          rx_data <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend with CLK_DIV=4 (64-cycle bit period).
// Expected frames go into exp_q at send time; a monitor logs DUT strobes into obs_q.
module tb_uart_rx_frontend;

    localparam int CLK_DIV = 4;
    localparam int BIT     = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = (16 * 10 + 10) * CLK_DIV;
`else
    localparam int LAT = (16 * 9 + 10) * CLK_DIV;
`endif

    typedef struct packed {
        logic        err;
        logic [7:0]  data;
        logic [31:0] lat;
    } ev_t;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       RX;
    logic       rx_status, frame_err, rx_busy;
    logic [7:0] rx_data;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  overlap = 0;
    int  wide = 0;
    int  data_bad = 0;
    logic       busy_d = 1'b0, status_d = 1'b0, ferr_d = 1'b0, rst_d = 1'b1;
    logic [7:0] data_d = 8'h00;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_frontend #(.CLK_DIV(CLK_DIV)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .RX        (RX),
        .rx_status (rx_status),
        .rx_data   (rx_data),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (rx_busy && !busy_d) start_cyc <= cyc;
        if (rx_status) obs_q.push_back('{err: 1'b0, data: rx_data, lat: 32'(cyc - start_cyc)});
        if (frame_err) obs_q.push_back('{err: 1'b1, data: rx_data, lat: 32'(cyc - start_cyc)});
        if (rx_status && frame_err) overlap <= overlap + 1;
        if ((rx_status && status_d) || (frame_err && ferr_d)) wide <= wide + 1;
        if (!rst_d && (rx_data !== data_d) && !rx_status) data_bad <= data_bad + 1;
        busy_d   <= rx_busy;
        status_d <= rx_status;
        ferr_d   <= frame_err;
        data_d   <= rx_data;
        rst_d    <= reset;
    end

    task automatic send_bit(input logic v);
        RX = v;
        repeat (BIT) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_v);
    endtask

    task automatic test_reset;
        RX = 1'b1;
        reset = 1'b1;
        repeat (5) @(posedge sysclk);
        #1 reset = 1'b0;
        checks++; if (rx_status !== 1'b0) begin errors++; $display("FAIL reset_status got=%b want=0", rx_status); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", rx_busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", rx_data); end
        repeat (20) @(posedge sysclk);
        #1;
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", rx_busy); end
    endtask

    task automatic test_single;
        ev_t e, o;
        exp_q.push_back('{err: 1'b0, data: 8'hA5, lat: 32'(LAT)});
        send_frame(8'hA5, 1'b1);
        repeat (BIT) @(posedge sysclk);
        #1;
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d want=1", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL single_missing got=none want=%h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || o.data !== e.data) begin
                    errors++; $display("FAIL single_event got=err%b/%h want=err%b/%h", o.err, o.data, e.err, e.data);
                end
                checks++;
                if (int'(o.lat) < int'(e.lat) - 1 || int'(o.lat) > int'(e.lat) + 1) begin
                    errors++; $display("FAIL single_latency got=%0d want=%0d+-1", o.lat, e.lat);
                end
            end
        end
        obs_q.delete();
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_hold got=%h want=a5", rx_data); end
    endtask

    task automatic test_back_to_back;
        ev_t e, o;
        exp_q.push_back('{err: 1'b0, data: 8'h00, lat: 32'(LAT)});
        exp_q.push_back('{err: 1'b0, data: 8'hFF, lat: 32'(LAT)});
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (BIT) @(posedge sysclk);
        #1;
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d want=2", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL b2b_missing got=none want=%h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || o.data !== e.data) begin
                    errors++; $display("FAIL b2b_event got=err%b/%h want=err%b/%h", o.err, o.data, e.err, e.data);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_glitch;
        RX = 1'b0;
        repeat (20) @(posedge sysclk);
        #1 RX = 1'b1;
        repeat (100) @(posedge sysclk);
        #1;
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_events got=%0d want=0", obs_q.size()); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b want=0", rx_busy); end
        checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL glitch_data got=%h want=ff", rx_data); end
        obs_q.delete();
    endtask

    task automatic test_frame_error;
        ev_t e, o;
        exp_q.push_back('{err: 1'b1, data: 8'hFF, lat: 32'(LAT)});
        send_frame(8'h3C, 1'b0);
        RX = 1'b0;
        repeat (500) @(posedge sysclk);
        #1 RX = 1'b1;
        repeat (100) @(posedge sysclk);
        #1;
        exp_q.push_back('{err: 1'b0, data: 8'h81, lat: 32'(LAT)});
        send_frame(8'h81, 1'b1);
        repeat (BIT) @(posedge sysclk);
        #1;
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL ferr_count got=%0d want=2", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL ferr_missing got=none want=err%b/%h", e.err, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || o.data !== e.data) begin
                    errors++; $display("FAIL ferr_event got=err%b/%h want=err%b/%h", o.err, o.data, e.err, e.data);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        ev_t e, o;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        RX = 1'b1;
        repeat (BIT / 2) @(posedge sysclk);
        #1 reset = 1'b1;
        @(posedge sysclk);
        #1 reset = 1'b0;
        checks++; if ({rx_status, frame_err, rx_busy} !== 3'b000) begin
            errors++; $display("FAIL midrst_flags got=%b want=000", {rx_status, frame_err, rx_busy}); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h want=00", rx_data); end
        repeat (200) @(posedge sysclk);
        #1;
        exp_q.push_back('{err: 1'b0, data: 8'hC3, lat: 32'(LAT)});
        send_frame(8'hC3, 1'b1);
        repeat (BIT) @(posedge sysclk);
        #1;
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL midrst_count got=%0d want=1", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL midrst_missing got=none want=%h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || o.data !== e.data) begin
                    errors++; $display("FAIL midrst_event got=err%b/%h want=err%b/%h", o.err, o.data, e.err, e.data);
                end
            end
        end
        obs_q.delete();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        ev_t e, o;
        exp_q.push_back('{err: 1'b0, data: 8'h07, lat: 32'(LAT)});
        send_frame(8'h07, 1'b1);
        par_flip = 1'b1;
        exp_q.push_back('{err: 1'b1, data: 8'h07, lat: 32'(LAT)});
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        repeat (BIT) @(posedge sysclk);
        #1;
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL parity_count got=%0d want=2", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL parity_missing got=none want=err%b/%h", e.err, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || o.data !== e.data) begin
                    errors++; $display("FAIL parity_event got=err%b/%h want=err%b/%h", o.err, o.data, e.err, e.data);
                end
            end
        end
        obs_q.delete();
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++; if (overlap != 0) begin errors++; $display("FAIL strobe_overlap got=%0d want=0", overlap); end
        checks++; if (wide != 0) begin errors++; $display("FAIL strobe_width got=%0d want=0", wide); end
        checks++; if (data_bad != 0) begin errors++; $display("FAIL data_without_strobe got=%0d want=0", data_bad); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
